// File: rtl/if_stage_if.sv
// Fetch-stage bundle: redirect/stall controls from the pipeline, ROM port, IF/ID outputs.
// master = fetch stage side, slave = surrounding pipeline / ROM / testbench side.
// Pure wiring, no storage.
interface if_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] jump_addr_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        id_valid_o;
    logic [31:0] fetch_cnt_o;

    modport master (
        input  stall_i, flush_i, jump_addr_i, rom_inst_i,
        output rom_ce_o, rom_addr_o, id_inst_o, id_pc_o, id_valid_o, fetch_cnt_o
    );

    modport slave (
        output stall_i, flush_i, jump_addr_i, rom_inst_i,
        input  rom_ce_o, rom_addr_o, id_inst_o, id_pc_o, id_valid_o, fetch_cnt_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC, ROM addressing, IF/ID register, redirect bubbles, fetch counter.
// Latency: one clock from rom_addr_o to id_inst_o; one instruction per clock unstalled.
// Backpressure: stall_i freezes PC and IF/ID indefinitely; flush_i overrides stall_i.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    // PC kept as a word index; the byte PC's two low bits are always zero.
    logic [29:0] pc_word;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] fetch_cnt;
    // Jump targets are aligned down, so their low bits are deliberately dropped.
    logic        jump_lsb_unused;

    assign jump_lsb_unused = ^bus.jump_addr_i[1:0];

    // State register: IDLE on reset, leaves it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: IDLE always advances, FETCH is terminal until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register and PC; reset drops rom_ce_o at once.
    always_comb begin
        bus.rom_ce_o    = (state == FETCH);
        bus.rom_addr_o  = {2'b00, pc_word};
        bus.id_inst_o   = id_inst;
        bus.id_pc_o     = id_pc;
        bus.id_valid_o  = id_valid;
        bus.fetch_cnt_o = fetch_cnt;
    end

    // PC and IF/ID update: flush beats stall, stall beats normal fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_word   <= RESET_PC[31:2];
            id_inst   <= NOP_INST;
            id_pc     <= 32'h0;
            id_valid  <= 1'b0;
            fetch_cnt <= 32'h0;
        end else if (state == IDLE) begin
            // Only a redirect matters before fetching starts; IF/ID untouched.
            if (bus.flush_i) pc_word <= bus.jump_addr_i[31:2];
        end else if (bus.flush_i) begin
            pc_word  <= bus.jump_addr_i[31:2];
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!bus.stall_i) begin
            id_inst   <= bus.rom_inst_i;
            id_pc     <= {pc_word, 2'b00};
            id_valid  <= 1'b1;
            pc_word   <= pc_word + 30'd1;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized stall/flush traffic
// compared each cycle against a behavioural model of the fetch stream.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    if_stage_if bus();

    if_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: words 0..3 are 11111111..44444444, others a scrambled pattern.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'd4) return (a + 32'd1) * 32'h1111_1111;
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
    endfunction

    assign bus.rom_inst_i = rom_word(bus.rom_addr_o);

    // Behavioural model: byte PC, whether fetching has begun, IF/ID contents, counter.
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_idpc;
    logic        m_vld;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_run  = 1'b0;
        m_pc   = 32'h0;
        m_inst = NOP;
        m_idpc = 32'h0;
        m_vld  = 1'b0;
        m_cnt  = 32'h0;
    endtask

    task automatic model_edge(input bit stall, input bit flush, input logic [31:0] ja);
        if (!m_run) begin
            if (flush) m_pc = ja & ~32'd3;
            m_run = 1'b1;
        end else if (flush) begin
            m_pc   = ja & ~32'd3;
            m_inst = NOP;
            m_vld  = 1'b0;
        end else if (!stall) begin
            m_inst = rom_word(m_pc / 4);
            m_idpc = m_pc;
            m_vld  = 1'b1;
            m_pc   = m_pc + 32'd4;
            m_cnt  = m_cnt + 32'd1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rom_ce"},   {31'h0, bus.rom_ce_o},   {31'h0, m_run});
        check({tag, ".rom_addr"}, bus.rom_addr_o,          m_pc / 4);
        check({tag, ".id_inst"},  bus.id_inst_o,           m_inst);
        check({tag, ".id_pc"},    bus.id_pc_o,             m_idpc);
        check({tag, ".id_valid"}, {31'h0, bus.id_valid_o}, {31'h0, m_vld});
        check({tag, ".cnt"},      bus.fetch_cnt_o,         m_cnt);
    endtask

    // Drive inputs, take one edge, advance the model, compare just after the edge.
    task automatic step(input string tag, input bit stall, input bit flush, input logic [31:0] ja);
        bus.stall_i     = stall;
        bus.flush_i     = flush;
        bus.jump_addr_i = ja;
        @(posedge clk);
        model_edge(stall, flush, ja);
        #1;
        check_all(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("idle_cycle");
    endtask

    initial begin
        bit st, fl;
        logic [31:0] ja;

        rst_n           = 1'b0;
        bus.stall_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.jump_addr_i = 32'h0;
        #12;
        model_reset();
        check_all("reset");
        release_reset();

        // Start-up stream from RESET_PC.
        step("c0", 0, 0, 0);
        step("c1", 0, 0, 0);
        check("first_inst", bus.id_inst_o, 32'h1111_1111);
        step("c2", 0, 0, 0);
        check("second_inst", bus.id_inst_o, 32'h2222_2222);
        check("second_pc", bus.id_pc_o, 32'h4);
        check("cnt_two", bus.fetch_cnt_o, 32'd2);

        // Stall three cycles while id_pc is 4, then release.
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0);
        check("stall_addr", bus.rom_addr_o, 32'd2);
        step("unstall", 0, 0, 0);
        check("unstall_pc", bus.id_pc_o, 32'h8);

        // Flush together with stall to a misaligned target.
        step("flush", 1, 1, 32'h0000_0013);
        check("flush_addr", bus.rom_addr_o, 32'd4);
        check("flush_bubble", {31'h0, bus.id_valid_o}, 32'd0);
        step("post_flush", 0, 0, 0);
        check("target_pc", bus.id_pc_o, 32'h10);

        // PC wrap at the top of the address space.
        step("wrap_flush", 0, 1, 32'hFFFF_FFFC);
        check("wrap_addr0", bus.rom_addr_o, 32'h3FFF_FFFF);
        step("wrap1", 0, 0, 0);
        check("wrap_pc_top", bus.id_pc_o, 32'hFFFF_FFFC);
        step("wrap2", 0, 0, 0);
        check("wrap_pc_zero", bus.id_pc_o, 32'h0);
        check("wrap_addr2", bus.rom_addr_o, 32'h1);

        // Asynchronous reset in mid-cycle while fetching.
        @(posedge clk);
        model_edge(bus.stall_i, bus.flush_i, bus.jump_addr_i);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_ce", {31'h0, bus.rom_ce_o}, 32'd0);
        release_reset();

        // Redirect requested during the IDLE cycle; stall there is ignored.
        step("idle_flush", 1, 1, 32'h40);
        step("idle_first", 0, 0, 0);
        check("idle_first_pc", bus.id_pc_o, 32'h40);
        check("idle_first_cnt", bus.fetch_cnt_o, 32'd1);

        // Randomized stall/flush traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                release_reset();
            end
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            ja = $urandom();
            if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hF);
            step("rnd", st, fl, ja);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
